// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache with same-cycle hit,
// line-straddling RVC support and a word-beat line refill engine.
module inst_fetch_cache #(
    parameter int LINE_BIT  = 4,
    parameter int INDEX_BIT = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        inst_req,
    input  logic [31:0] pc_in,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        mem_busy,
    output logic        refill_req,
    output logic [31:0] refill_addr,
    input  logic        refill_valid,
    input  logic [31:0] refill_data
);

    localparam int NLINE = 1 << INDEX_BIT;
    localparam int BEATS = 1 << (LINE_BIT - 2);
    localparam int LINEW = BEATS * 32;
    localparam int TAGW  = 32 - LINE_BIT - INDEX_BIT;
    localparam int LNW   = 32 - LINE_BIT;
    localparam int HW    = LINE_BIT - 1;
    localparam int CNTW  = (LINE_BIT > 2) ? LINE_BIT - 2 : 1;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_e;

    logic [NLINE-1:0] valid_q;
    logic [TAGW-1:0]  tag_q  [NLINE];
    logic [LINEW-1:0] data_q [NLINE];

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [LNW-1:0]   addr_q, addr_d;
    logic [LINEW-1:0] buf_q, buf_d;
    logic             fill;

    logic [LNW-1:0]       ln0, ln1, miss_ln;
    logic [INDEX_BIT-1:0] idx0, idx1, widx;
    logic [TAGW-1:0]      tag0, tag1, wtag;
    logic [LINE_BIT-1:0]  off;
    logic [HW-1:0]        h, hn;
    logic [LINEW-1:0]     line0;
    logic                 hit0, hit1, straddle, lo_rvc;
    logic [15:0]          lo_half, hi_half;

    // Line numbers of the pc line and the following (wrapping) line
    assign ln0  = pc_in[31:LINE_BIT];
    assign ln1  = ln0 + LNW'(1);
    assign idx0 = ln0[INDEX_BIT-1:0];
    assign idx1 = ln1[INDEX_BIT-1:0];
    assign tag0 = ln0[LNW-1:INDEX_BIT];
    assign tag1 = ln1[LNW-1:INDEX_BIT];
    assign off  = pc_in[LINE_BIT-1:0];
    assign h    = off[LINE_BIT-1:1];
    assign hn   = h + HW'(1);

    assign straddle = (off == {{HW{1'b1}}, 1'b0});
    assign line0    = data_q[idx0];
    assign hit0     = valid_q[idx0] && (tag_q[idx0] == tag0);
    assign hit1     = valid_q[idx1] && (tag_q[idx1] == tag1);
    assign lo_half  = line0[{h, 4'b0000} +: 16];
    assign hi_half  = straddle ? data_q[idx1][15:0]
                               : line0[{hn, 4'b0000} +: 16];
    assign lo_rvc   = (lo_half[1:0] != 2'b11);
    assign miss_ln  = hit0 ? ln1 : ln0;

    always_comb begin
        inst_ready = 1'b0;
        inst_out   = '0;
        if (inst_req && rdy_in && hit0) begin
            if (!straddle || hit1) begin
                inst_ready = 1'b1;
                inst_out   = {hi_half, lo_half};
            end else if (lo_rvc) begin
                inst_ready = 1'b1;
                inst_out   = {16'h0000, lo_half};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            if (fill) valid_q[widx] <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        fill    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (inst_req && rdy_in && !inst_ready) begin
                    state_d = S_REFILL;
                    addr_d  = miss_ln;
                    cnt_d   = '0;
                end
            end
            S_REFILL: begin
                if (rdy_in && refill_valid) begin
                    buf_d[{cnt_q, 5'b00000} +: 32] = refill_data;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(BEATS - 1)) begin
                        fill    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        refill_req  = (state_q == S_REFILL);
        mem_busy    = (state_q == S_REFILL);
        refill_addr = {addr_q, {LINE_BIT{1'b0}}};
    end

    assign widx = addr_q[INDEX_BIT-1:0];
    assign wtag = addr_q[LNW-1:INDEX_BIT];

    // Arrays are written only once the whole line has arrived
    always_ff @(posedge clk_in) begin
        if (fill) begin
            data_q[widx] <= buf_d;
            tag_q[widx]  <= wtag;
        end
    end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Scoreboard bench for inst_fetch_cache: memory model, residency
// model and per-scenario tasks.
module tb_inst_fetch_cache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_req;
    logic [31:0] pc_in;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        mem_busy;
    logic        refill_req;
    logic [31:0] refill_addr;
    logic        refill_valid;
    logic [31:0] refill_data;

    int vectors = 0;
    int fails   = 0;

    logic [32:0] exp_q [$];
    logic [31:0] mem [logic [31:0]];
    bit   [63:0] res_v;
    logic [31:0] res_l [64];

    inst_fetch_cache dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .inst_req     (inst_req),
        .pc_in        (pc_in),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
        .mem_busy     (mem_busy),
        .refill_req   (refill_req),
        .refill_addr  (refill_addr),
        .refill_valid (refill_valid),
        .refill_data  (refill_data)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A03;
    endfunction

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] x;
        x = memw({a[31:2], 2'b00});
        return a[1] ? x[31:16] : x[15:0];
    endfunction

    function automatic bit hitm(input logic [31:0] a);
        int i;
        i = int'((a >> 4) & 32'd63);
        return res_v[i] && (res_l[i] == {a[31:4], 4'h0});
    endfunction

    function automatic void model(input logic [31:0] pc,
                                  output logic r, output logic [31:0] w);
        logic [31:0] l0;
        logic [15:0] lo;
        l0 = {pc[31:4], 4'h0};
        lo = half(pc);
        r  = 1'b0;
        w  = 32'h0;
        if (rdy_in !== 1'b1) return;
        if (pc[3:0] != 4'hE) begin
            if (hitm(l0)) begin
                r = 1'b1;
                w = {half(pc + 32'd2), lo};
            end
        end else if (hitm(l0) && hitm(l0 + 32'd16)) begin
            r = 1'b1;
            w = {half(pc + 32'd2), lo};
        end else if (hitm(l0) && lo[1:0] != 2'b11) begin
            r = 1'b1;
            w = {16'h0, lo};
        end
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        logic        r;
        logic [31:0] w;
        logic [32:0] e;
        inst_req = 1'b1;
        pc_in    = pc;
        model(pc, r, w);
        exp_q.push_back({r, w});
        #2;
        e = exp_q.pop_front();
        vectors++;
        if ({inst_ready, inst_out} !== e) begin
            fails++;
            $display("FAIL fetch pc=%h: got rdy=%b out=%h, want rdy=%b out=%h",
                     pc, inst_ready, inst_out, e[32], e[31:0]);
        end
    endtask

    task automatic feed(input logic [31:0] line, input bit hit_en,
                        input logic [31:0] hpc, input bit gap);
        for (int b = 0; b < 4; b++) begin
            if (gap && b == 1) begin
                rdy_in       = 1'b0;
                refill_valid = 1'b1;
                refill_data  = 32'hDEAD_BEEF;
                if (hit_en) fetch(hpc);
                step();
                vectors++;
                if (refill_req !== 1'b1) begin
                    fails++;
                    $display("FAIL rdy_gap_hold: refill_req=%b want 1", refill_req);
                end
                rdy_in = 1'b1;
            end
            refill_valid = 1'b1;
            refill_data  = memw(line + 32'(4 * b));
            if (hit_en) begin
                fetch(hpc);
                vectors++;
                if (refill_addr !== line) begin
                    fails++;
                    $display("FAIL addr_stable: refill_addr=%h want %h",
                             refill_addr, line);
                end
            end
            step();
            if (b < 3) begin
                vectors++;
                if (refill_req !== 1'b1 || mem_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL refill_hold beat %0d: req=%b busy=%b want 1/1",
                             b, refill_req, mem_busy);
                end
            end
        end
        refill_valid = 1'b0;
        refill_data  = 32'h0;
        vectors++;
        if (refill_req !== 1'b0 || mem_busy !== 1'b0) begin
            fails++;
            $display("FAIL refill_done %h: req=%b busy=%b want 0/0",
                     line, refill_req, mem_busy);
        end
        res_v[(line >> 4) & 32'd63] = 1'b1;
        res_l[(line >> 4) & 32'd63] = line;
        if (hit_en) inst_req = 1'b0;
    endtask

    task automatic miss_and_fill(input logic [31:0] pc, input logic [31:0] line);
        fetch(pc);
        step();
        inst_req = 1'b0;
        vectors++;
        if (refill_req !== 1'b1 || mem_busy !== 1'b1 || refill_addr !== line) begin
            fails++;
            $display("FAIL refill_start: req=%b busy=%b addr=%h want 1/1/%h",
                     refill_req, mem_busy, refill_addr, line);
        end
        feed(line, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; inst_req = 1'b1; pc_in = 32'h0;
        refill_valid = 1'b0; refill_data = 32'h0; res_v = '0;
        #2;
        vectors++;
        if (refill_req !== 1'b0 || mem_busy !== 1'b0 || refill_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: req=%b busy=%b addr=%h want 0/0/0",
                     refill_req, mem_busy, refill_addr);
        end
        vectors++;
        if (inst_ready !== 1'b0 || inst_out !== 32'h0) begin
            fails++;
            $display("FAIL reset_out: rdy=%b out=%h want 0/0", inst_ready, inst_out);
        end
        inst_req = 1'b0;
        step();
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        mem[32'h0] = 32'h0000_0013; mem[32'h4] = 32'h0010_0093;
        mem[32'h8] = 32'h0020_0113; mem[32'hC] = 32'h0030_0193;
        miss_and_fill(32'h0, 32'h0);
        fetch(32'h4);
        vectors++;
        if (inst_out !== 32'h0010_0093) begin
            fails++;
            $display("FAIL cold_word: out=%h want 00100093", inst_out);
        end
        fetch(32'h0); fetch(32'h8); fetch(32'h2); fetch(32'hA);
        inst_req = 1'b0;
    endtask

    task automatic test_straddle();
        fetch(32'hE);
        inst_req = 1'b0;
        miss_and_fill(32'h10, 32'h10);
        fetch(32'hE);
        inst_req = 1'b0;
        mem[32'h10C] = 32'h4501_0000;
        miss_and_fill(32'h100, 32'h100);
        fetch(32'h10E);
        step();
        vectors++;
        if (refill_req !== 1'b0) begin
            fails++;
            $display("FAIL rvc_no_refill: refill_req=%b want 0", refill_req);
        end
        inst_req = 1'b0;
        mem[32'h20C] = 32'h0093_0000;
        miss_and_fill(32'h200, 32'h200);
        miss_and_fill(32'h20E, 32'h210);
        fetch(32'h20E);
        inst_req = 1'b0;
        miss_and_fill(32'hFFFF_FFF0, 32'hFFFF_FFF0);
        fetch(32'hFFFF_FFFE);
        inst_req = 1'b0;
    endtask

    task automatic test_conflict();
        miss_and_fill(32'h400, 32'h400);
        miss_and_fill(32'h0, 32'h0);
        fetch(32'hC);
        inst_req = 1'b0;
    endtask

    task automatic test_hit_during_refill();
        fetch(32'h500);
        step();
        feed(32'h500, 1'b1, 32'h4, 1'b1);
        fetch(32'h500); fetch(32'h504); fetch(32'h50C);
        inst_req = 1'b0;
    endtask

    task automatic test_rdy_low();
        rdy_in = 1'b0;
        fetch(32'h4);
        fetch(32'h800);
        step();
        vectors++;
        if (refill_req !== 1'b0) begin
            fails++;
            $display("FAIL rdy_low_start: refill_req=%b want 0", refill_req);
        end
        inst_req = 1'b0;
        rdy_in = 1'b1;
    endtask

    task automatic test_back_to_back();
        miss_and_fill(32'h600, 32'h600);
        fetch(32'h6F0);
        step();
        inst_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            refill_valid = 1'b1;
            refill_data  = memw(32'h6F0 + 32'(4 * b));
            if (b == 3) begin inst_req = 1'b1; pc_in = 32'h700; end
            step();
        end
        refill_valid = 1'b0;
        res_v[(32'h6F0 >> 4) & 32'd63] = 1'b1;
        res_l[(32'h6F0 >> 4) & 32'd63] = 32'h6F0;
        vectors++;
        if (refill_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: refill_req=%b want 0", refill_req);
        end
        fetch(32'h700);
        step();
        inst_req = 1'b0;
        vectors++;
        if (refill_req !== 1'b1 || refill_addr !== 32'h700) begin
            fails++;
            $display("FAIL b2b_restart: req=%b addr=%h want 1/00000700",
                     refill_req, refill_addr);
        end
        feed(32'h700, 1'b0, 32'h0, 1'b0);
        fetch(32'h704); fetch(32'h6F4); fetch(32'h600);
        inst_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        fetch(32'h900);
        step();
        inst_req = 1'b0;
        for (int b = 0; b < 2; b++) begin
            refill_valid = 1'b1;
            refill_data  = memw(32'h900 + 32'(4 * b));
            step();
        end
        refill_valid = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        vectors++;
        if (refill_req !== 1'b0 || mem_busy !== 1'b0 || refill_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: req=%b busy=%b addr=%h want 0/0/0",
                     refill_req, mem_busy, refill_addr);
        end
        res_v = '0;
        fetch(32'h4);
        inst_req = 1'b0;
        step();
        #2 rst_in = 1'b1;
        step();
        miss_and_fill(32'h0, 32'h0);
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        inst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_straddle();
        test_conflict();
        test_hit_during_refill();
        test_rdy_low();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
